// File: rtl/riscv_core_div_ctrl.sv
// Sequencing controller for the iterative divider: request handshake, divider enable,
// flush-safe draining and tagged writeback. Optional fast path under `DIV_FASTPATH_EN`.
module riscv_core_div_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_div_ctrl_clk,
  input  logic             i_div_ctrl_rstn,
  input  logic             i_div_ctrl_valid,
  output logic             o_div_ctrl_ready,
  input  logic [XLEN-1:0]  i_div_ctrl_srcA,
  input  logic [XLEN-1:0]  i_div_ctrl_srcB,
  input  logic [1:0]       i_div_ctrl_control,
  input  logic             i_div_ctrl_isword,
  input  logic [TAG_W-1:0] i_div_ctrl_rd,
  input  logic             i_div_ctrl_flush,
  output logic             o_div_ctrl_busy,
  output logic [XLEN-1:0]  o_div_ctrl_div_srcA,
  output logic [XLEN-1:0]  o_div_ctrl_div_srcB,
  output logic [1:0]       o_div_ctrl_div_control,
  output logic             o_div_ctrl_div_isword,
  output logic             o_div_ctrl_div_en,
  input  logic             i_div_ctrl_div_done,
  input  logic [XLEN-1:0]  i_div_ctrl_div_result,
  output logic             o_div_ctrl_wb_valid,
  input  logic             i_div_ctrl_wb_ready,
  output logic [TAG_W-1:0] o_div_ctrl_wb_rd,
  output logic [XLEN-1:0]  o_div_ctrl_wb_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StWb} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  srca_q, srcb_q;
  logic [1:0]       control_q;
  logic             isword_q;
  logic [TAG_W-1:0] rd_q;
  logic [XLEN-1:0]  result_q, result_d;
  logic             accept;
  logic             fast_hit;
  logic [XLEN-1:0]  fast_result;

  assign accept = (state_q == StIdle) & i_div_ctrl_valid & ~i_div_ctrl_flush;

`ifdef DIV_FASTPATH_EN
  logic            b_zero, ovf, is_rem, is_signed;
  logic [XLEN-1:0] a_ext;

  // Divide-by-zero and signed overflow have fixed architectural results.
  always_comb begin
    is_rem    = i_div_ctrl_control[1];
    is_signed = ~i_div_ctrl_control[0];
    a_ext     = i_div_ctrl_isword ?
                {{(XLEN-32){i_div_ctrl_srcA[31]}}, i_div_ctrl_srcA[31:0]} : i_div_ctrl_srcA;
    if (i_div_ctrl_isword) begin
      b_zero = (i_div_ctrl_srcB[31:0] == 32'd0);
      ovf    = is_signed & (i_div_ctrl_srcA[31:0] == 32'h8000_0000) &
               (i_div_ctrl_srcB[31:0] == 32'hFFFF_FFFF);
    end else begin
      b_zero = (i_div_ctrl_srcB == '0);
      ovf    = is_signed & (i_div_ctrl_srcA == {1'b1, {(XLEN-1){1'b0}}}) &
               (i_div_ctrl_srcB == '1);
    end
    fast_hit = b_zero | ovf;
    if (b_zero) fast_result = is_rem ? a_ext : '1;
    else        fast_result = is_rem ? '0 : a_ext;
  end
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (fast_hit) begin
            state_d  = StWb;
            result_d = fast_result;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (i_div_ctrl_flush) begin
          state_d = i_div_ctrl_div_done ? StIdle : StDrain;
        end else if (i_div_ctrl_div_done) begin
          state_d  = StWb;
          result_d = i_div_ctrl_div_result;
        end
      end
      // Keep the divider enabled until it finishes; its result is thrown away.
      StDrain: if (i_div_ctrl_div_done) state_d = StIdle;
      StWb:    if (i_div_ctrl_flush | i_div_ctrl_wb_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
    if (!i_div_ctrl_rstn) begin
      state_q   <= StIdle;
      srca_q    <= '0;
      srcb_q    <= '0;
      control_q <= '0;
      isword_q  <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        srca_q    <= i_div_ctrl_srcA;
        srcb_q    <= i_div_ctrl_srcB;
        control_q <= i_div_ctrl_control;
        isword_q  <= i_div_ctrl_isword;
        rd_q      <= i_div_ctrl_rd;
      end
    end
  end

  always_comb begin
    o_div_ctrl_ready    = (state_q == StIdle);
    o_div_ctrl_busy     = (state_q != StIdle);
    o_div_ctrl_div_en   = (state_q == StRun) | (state_q == StDrain);
    o_div_ctrl_wb_valid = (state_q == StWb);
  end

  assign o_div_ctrl_div_srcA    = srca_q;
  assign o_div_ctrl_div_srcB    = srcb_q;
  assign o_div_ctrl_div_control = control_q;
  assign o_div_ctrl_div_isword  = isword_q;
  assign o_div_ctrl_wb_rd       = rd_q;
  assign o_div_ctrl_wb_result   = result_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed bench for riscv_core_div_ctrl with a transaction-level reference model.
module tb_riscv_core_div_ctrl;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             valid = 1'b0, flush = 1'b0, isword = 1'b0;
  logic [XLEN-1:0]  srca = '0, srcb = '0, div_result = '0;
  logic [1:0]       control = '0;
  logic [TAG_W-1:0] rd = '0;
  logic             div_done = 1'b0, wb_ready = 1'b0;
  logic             ready, busy, div_isword, div_en, wb_valid;
  logic [XLEN-1:0]  div_srca, div_srcb, wb_result;
  logic [1:0]       div_control;
  logic [TAG_W-1:0] wb_rd;

  int checks = 0;
  int errors = 0;

  riscv_core_div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_div_ctrl_clk        (clk),
    .i_div_ctrl_rstn       (rstn),
    .i_div_ctrl_valid      (valid),
    .o_div_ctrl_ready      (ready),
    .i_div_ctrl_srcA       (srca),
    .i_div_ctrl_srcB       (srcb),
    .i_div_ctrl_control    (control),
    .i_div_ctrl_isword     (isword),
    .i_div_ctrl_rd         (rd),
    .i_div_ctrl_flush      (flush),
    .o_div_ctrl_busy       (busy),
    .o_div_ctrl_div_srcA   (div_srca),
    .o_div_ctrl_div_srcB   (div_srcb),
    .o_div_ctrl_div_control(div_control),
    .o_div_ctrl_div_isword (div_isword),
    .o_div_ctrl_div_en     (div_en),
    .i_div_ctrl_div_done   (div_done),
    .i_div_ctrl_div_result (div_result),
    .o_div_ctrl_wb_valid   (wb_valid),
    .i_div_ctrl_wb_ready   (wb_ready),
    .o_div_ctrl_wb_rd      (wb_rd),
    .o_div_ctrl_wb_result  (wb_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension arithmetic
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] ctl, input logic w);
    int sa, sb;
    int unsigned ua, ub;
    longint la, lb;
    longint unsigned xa, xb;
    logic [31:0] q32, r32;
    logic [63:0] q, r;
    if (w) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (ub == 0) begin
        q32 = '1; r32 = a[31:0];
      end else if (!ctl[0] && sa == 32'sh8000_0000 && sb == -1) begin
        q32 = a[31:0]; r32 = '0;
      end else if (!ctl[0]) begin
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = ua / ub; r32 = ua % ub;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      la = a; lb = b; xa = a; xb = b;
      if (xb == 0) begin
        q = '1; r = a;
      end else if (!ctl[0] && la == 64'sh8000_0000_0000_0000 && lb == -1) begin
        q = a; r = '0;
      end else if (!ctl[0]) begin
        q = la / lb; r = la % lb;
      end else begin
        q = xa / xb; r = xa % xb;
      end
    end
    return ctl[1] ? r : q;
  endfunction

  function automatic bit special_case(input logic [63:0] a, input logic [63:0] b,
                                      input logic [1:0] ctl, input logic w);
    bit bz, ov;
    bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = !ctl[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    return bz || ov;
  endfunction

  // Model phases: 0 idle, 1 dividing, 2 draining after flush, 3 result pending.
  int          m_ph;
  logic [63:0] m_a, m_b, m_res;
  logic [1:0]  m_ctl;
  logic        m_w;
  logic [4:0]  m_rd;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph <= 0; m_a <= '0; m_b <= '0; m_res <= '0; m_ctl <= '0; m_w <= 1'b0; m_rd <= '0;
    end else begin
      case (m_ph)
        0: if (valid && !flush) begin
          m_a <= srca; m_b <= srcb; m_ctl <= control; m_w <= isword; m_rd <= rd;
          if (FAST && special_case(srca, srcb, control, isword)) begin
            m_ph  <= 3;
            m_res <= ref_div(srca, srcb, control, isword);
          end else begin
            m_ph <= 1;
          end
        end
        1: if (flush) m_ph <= div_done ? 0 : 2;
           else if (div_done) begin m_ph <= 3; m_res <= div_result; end
        2: if (div_done) m_ph <= 0;
        default: if (flush || wb_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("ready", ready, m_ph == 0);
    check("busy", busy, m_ph != 0);
    check("div_en", div_en, m_ph == 1 || m_ph == 2);
    check("wb_valid", wb_valid, m_ph == 3);
    if (m_ph == 1 || m_ph == 2) begin
      check("div_srcA", div_srca, m_a);
      check("div_srcB", div_srcb, m_b);
      check("div_control", div_control, m_ctl);
      check("div_isword", div_isword, m_w);
    end
    if (m_ph == 3) begin
      check("wb_rd", wb_rd, m_rd);
      check("wb_result", wb_result, m_res);
    end
    if (!rstn) begin
      check("rst_div_srcA", div_srca, 0);
      check("rst_wb_result", wb_result, 0);
      check("rst_wb_rd", wb_rd, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                        input logic w, input logic [4:0] r);
    valid = 1'b1; srca = a; srcb = b; control = ctl; isword = w; rd = r;
    step();
    valid = 1'b0;
  endtask

  // lat: cycle (accept = 0) at which done is raised; flush_at: RUN-cycle flush (0 = none)
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                       input logic w, input logic [4:0] r, input int lat, input int flush_at,
                       input int hold, input bit wb_flush, input logic [63:0] exp);
    bit fast, flushed;
    fast = FAST && special_case(a, b, ctl, w);
    flushed = 1'b0;
    accept(a, b, ctl, w, r);
    if (!fast) begin
      for (int k = 1; k <= lat; k++) begin
        if (k == lat) begin div_done = 1'b1; div_result = ref_div(a, b, ctl, w); end
        if (k == flush_at) begin flush = 1'b1; flushed = 1'b1; end
        if (flushed && flush_at != 0 && k == flush_at + 2) flush = 1'b1;
        step();
        div_done = 1'b0; flush = 1'b0; div_result = '0;
      end
    end
    if (flushed) begin
      check("flush_ready", ready, 1);
      check("flush_no_wb", wb_valid, 0);
    end else begin
      check("lat_wb_valid", wb_valid, 1);
      check("lat_div_en", div_en, 0);
      check("lit_result", wb_result, exp);
      check("lit_rd", wb_rd, r);
      repeat (hold) step();
      wb_ready = 1'b1;
      flush = wb_flush;
      step();
      wb_ready = 1'b0; flush = 1'b0;
      check("post_wb_ready", ready, 1);
      check("post_wb_valid", wb_valid, 0);
    end
  endtask

  task automatic reset_pulse();
    #2 rstn = 1'b0;
    #1;
    check("async_ready", ready, 1);
    check("async_busy", busy, 0);
    check("async_div_en", div_en, 0);
    check("async_wb_valid", wb_valid, 0);
    check("async_div_srcA", div_srca, 0);
    check("async_wb_result", wb_result, 0);
    step();
    rstn = 1'b1;
  endtask

  initial begin
    repeat (2) step();
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    rstn = 1'b1;
    step();
    // done ignored in idle; flush together with valid blocks the accept
    div_done = 1'b1; step(); div_done = 1'b0;
    valid = 1'b1; flush = 1'b1; srca = 64'd5; srcb = 64'd1; step();
    valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", ready, 1);

    do_op(64'd100, 64'd7, 2'b01, 1'b0, 5'd5, 65, 0, 3, 1'b0, 64'd14);
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b10, 1'b1, 5'd9, 33, 0, 0, 1'b0, '1);
    do_op(-64'sd100, 64'd7, 2'b00, 1'b0, 5'd3, 20, 0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2);
    do_op(64'hFFFF_FFF0, 64'h10, 2'b01, 1'b1, 5'd12, 33, 0, 0, 1'b0, 64'h0FFF_FFFF);
    do_op(64'd1000, 64'd3, 2'b11, 1'b0, 5'd7, 40, 10, 0, 1'b0, 64'd1);
    do_op(64'd1000, 64'd3, 2'b00, 1'b0, 5'd8, 15, 15, 0, 1'b0, 64'd333);
    do_op(64'd42, 64'd0, 2'b00, 1'b0, 5'd10, 65, 0, 1, 1'b0, '1);
    do_op(64'd123, 64'd0, 2'b11, 1'b0, 5'd11, 65, 0, 0, 1'b0, 64'd123);
    do_op(64'h8000_0000, 64'hFFFF_FFFF, 2'b00, 1'b1, 5'd13, 33, 0, 0, 1'b0,
          64'hFFFF_FFFF_8000_0000);
    do_op(64'h8000_0000, 64'hFFFF_FFFF, 2'b10, 1'b1, 5'd14, 33, 0, 0, 1'b0, 64'd0);
    do_op(64'd50, 64'd5, 2'b00, 1'b0, 5'd15, 10, 0, 2, 1'b1, 64'd10);

    // reset mid-RUN, then a normal request
    accept(64'd77, 64'd7, 2'b01, 1'b0, 5'd20);
    repeat (5) step();
    reset_pulse();
    do_op(64'd77, 64'd7, 2'b01, 1'b0, 5'd21, 12, 0, 0, 1'b0, 64'd11);

    // reset mid-WB, then a normal request
    accept(64'd9, 64'd2, 2'b11, 1'b0, 5'd22);
    div_done = 1'b1; div_result = 64'd1; step(); div_done = 1'b0; div_result = '0;
    check("wb_before_reset", wb_valid, 1);
    reset_pulse();
    do_op(64'd9, 64'd2, 2'b11, 1'b0, 5'd23, 8, 0, 1, 1'b0, 64'd1);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
